// File: rtl/systolic_skew_feeder.sv
// Operand stager for an MxN systolic grid: buffers A (MxK) and B (KxN), streams them as skewed wavefronts.
// Latency: acc_clr 1 cycle after start, beat 0 after 2, done after K+M+N cycles; all outputs registered.
// Backpressure: none; start is ignored and writes are dropped while busy (except start on the final beat, which chains).
module systolic_skew_feeder #(
    parameter int M  = 4,
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [7:0]      wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    output logic            busy,
    output logic            acc_clr,
    output logic            valid,
    output logic [M*DW-1:0] a_out,
    output logic [N*DW-1:0] b_out,
    output logic            done
);

    localparam int S   = K + M + N - 2;
    localparam int TW  = $clog2(S + 1);
    localparam int AAW = (M * K > 1) ? $clog2(M * K) : 1;
    localparam int BAW = (K * N > 1) ? $clog2(K * N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t          state;
    logic [TW-1:0]   t;
    logic [TW-1:0]   t_nxt;
    logic [DW-1:0]   a_buf [M*K];
    logic [DW-1:0]   b_buf [K*N];
    logic [M*DW-1:0] a_nxt;
    logic [N*DW-1:0] b_nxt;

    // Buffers are frozen for the whole tile: writes only land while not busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int x = 0; x < M * K; x++) a_buf[x] <= '0;
            for (int x = 0; x < K * N; x++) b_buf[x] <= '0;
        end else if (wr_en && !busy) begin
            if (!wr_sel && int'(wr_addr) < M * K)
                a_buf[wr_addr[AAW-1:0]] <= wr_data;
            else if (wr_sel && int'(wr_addr) < K * N)
                b_buf[wr_addr[BAW-1:0]] <= wr_data;
        end
    end

    // Beat index that the next edge will present.
    always_comb begin
        t_nxt = '0;
        if (state == STREAM)
            t_nxt = t + TW'(1);
    end

    always_comb begin
        a_nxt = '0;
        for (int i = 0; i < M; i++) begin
            if (int'(t_nxt) >= i && int'(t_nxt) - i < K)
                a_nxt[i*DW +: DW] = a_buf[AAW'(i * K + int'(t_nxt) - i)];
        end
    end

    always_comb begin
        b_nxt = '0;
        for (int j = 0; j < N; j++) begin
            if (int'(t_nxt) >= j && int'(t_nxt) - j < K)
                b_nxt[j*DW +: DW] = b_buf[BAW'((int'(t_nxt) - j) * N + j)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            t       <= '0;
            busy    <= 1'b0;
            acc_clr <= 1'b0;
            valid   <= 1'b0;
            done    <= 1'b0;
            a_out   <= '0;
            b_out   <= '0;
        end else begin
            acc_clr <= 1'b0;
            valid   <= 1'b0;
            done    <= 1'b0;
            a_out   <= '0;
            b_out   <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        acc_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= STREAM;
                    t     <= t_nxt;
                    valid <= 1'b1;
                    a_out <= a_nxt;
                    b_out <= b_nxt;
                end
                STREAM: begin
                    if (t == TW'(S - 1)) begin
                        done <= 1'b1;
                        // start seen on the final beat overlaps the next clear with this done.
                        if (start) begin
                            state   <= CLEAR;
                            acc_clr <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        t     <= t_nxt;
                        valid <= 1'b1;
                        a_out <= a_nxt;
                        b_out <= b_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed + randomized bench for systolic_skew_feeder with a tile/grid reference model.
module tb_systolic_skew_feeder;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int K  = 4;
    localparam int DW = 16;
    localparam int S  = K + M + N - 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic            wr_sel;
    logic [7:0]      wr_addr;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            busy;
    logic            acc_clr;
    logic            valid;
    logic [M*DW-1:0] a_out;
    logic [N*DW-1:0] b_out;
    logic            done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]   ma [M][K];
    logic [DW-1:0]   mb [K][N];
    logic [M*DW-1:0] ah [S];
    logic [N*DW-1:0] bh [S];
    longint          gc [M][N];

    systolic_skew_feeder #(.M(M), .N(N), .K(K), .DW(DW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .acc_clr(acc_clr),
        .valid(valid), .a_out(a_out), .b_out(b_out), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [M*DW-1:0] exp_a(input int t);
        logic [M*DW-1:0] v = '0;
        for (int i = 0; i < M; i++)
            if (t - i >= 0 && t - i < K) v[i*DW +: DW] = ma[i][t-i];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_b(input int t);
        logic [N*DW-1:0] v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < K) v[j*DW +: DW] = mb[t-j][j];
        return v;
    endfunction

    task automatic wr(input logic sel, input int addr, input logic [DW-1:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 8'(addr); wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_tile();
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++) wr(1'b0, i * K + k, ma[i][k]);
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) wr(1'b1, k * N + j, mb[k][j]);
    endtask

    task automatic start_and_clear(input bit hold);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk("clr_acc_clr", 128'(acc_clr), 128'(1));
        chk("clr_busy", 128'(busy), 128'(1));
        chk("clr_valid", 128'(valid), 128'(0));
    endtask

    // Beat-by-beat check; optionally attempts a write (A addr 0 = 0xFFFF) during lock_beat.
    task automatic stream_beats(input int lock_beat);
        for (int t = 0; t < S; t++) begin
            @(negedge clk);
            wr_en = 1'b0;
            ah[t] = a_out;
            bh[t] = b_out;
            chk($sformatf("beat%0d_valid", t), 128'(valid), 128'(1));
            chk($sformatf("beat%0d_busy", t), 128'(busy), 128'(1));
            chk($sformatf("beat%0d_done", t), 128'(done), 128'(0));
            chk($sformatf("beat%0d_a", t), 128'(a_out), 128'(exp_a(t)));
            chk($sformatf("beat%0d_b", t), 128'(b_out), 128'(exp_b(t)));
            if (t == lock_beat) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = 16'hFFFF;
            end
        end
    endtask

    task automatic check_done(input bit chained);
        @(negedge clk);
        wr_en = 1'b0;
        chk("done_pulse", 128'(done), 128'(1));
        chk("done_valid", 128'(valid), 128'(0));
        chk("done_a_zero", 128'(a_out), 128'(0));
        chk("done_b_zero", 128'(b_out), 128'(0));
        chk("done_busy", 128'(busy), 128'(chained));
        chk("done_acc_clr", 128'(acc_clr), 128'(chained));
    endtask

    // Output-stationary grid: PE(i,j) sees A lane i delayed j and B lane j delayed i.
    task automatic grid_check(input bit ident);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                longint ref_c = 0;
                gc[i][j] = 0;
                for (int t = 0; t < S; t++)
                    if (t - j >= 0 && t - i >= 0)
                        gc[i][j] += longint'(ah[t-j][i*DW +: DW]) * longint'(bh[t-i][j*DW +: DW]);
                if (ident) ref_c = i + j;
                else for (int k = 0; k < K; k++) ref_c += longint'(ma[i][k]) * longint'(mb[k][j]);
                chk($sformatf("grid_c%0d%0d", i, j), 128'(gc[i][j]), 128'(ref_c));
            end
    endtask

    initial begin
        logic [DW-1:0] v5;
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        #2;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_acc_clr", 128'(acc_clr), 128'(0));
        chk("rst_valid", 128'(valid), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_a", 128'(a_out), 128'(0));
        chk("rst_b", 128'(b_out), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Skew pattern
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ma[i][k] = DW'(16 * i + k);
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) mb[k][j] = DW'(16'h100 + 4 * k + j);
        load_tile();
        start_and_clear(1'b0);
        stream_beats(-1);
        check_done(1'b0);
        chk("skew_b0_a", 128'(ah[0]), 128'(64'h0));
        chk("skew_b0_b", 128'(bh[0]), 128'(64'h0100));
        chk("skew_b3_a3", 128'(ah[3][3*DW +: DW]), 128'(16'h30));
        chk("skew_b3_a0", 128'(ah[3][0 +: DW]), 128'(16'h03));
        chk("skew_b6_a3", 128'(ah[6][3*DW +: DW]), 128'(16'h33));
        chk("skew_b6_b3", 128'(bh[6][3*DW +: DW]), 128'(16'h10F));
        chk("skew_b9_a", 128'(ah[9]), 128'(0));
        chk("skew_b9_b", 128'(bh[9]), 128'(0));
        grid_check(1'b0);

        // Golden identity tile
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ma[i][k] = DW'(i == k);
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) mb[k][j] = DW'(k + j);
        load_tile();
        start_and_clear(1'b0);
        stream_beats(-1);
        check_done(1'b0);
        grid_check(1'b1);

        // Random tiles
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ma[i][k] = DW'($urandom_range(0, 65535));
            for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) mb[k][j] = DW'($urandom_range(0, 65535));
            load_tile();
            start_and_clear(1'b0);
            stream_beats(-1);
            check_done(1'b0);
            grid_check(1'b0);
        end

        // Lock: write during beat 2 is dropped
        ma[0][0] = 16'h1234;
        wr(1'b0, 0, 16'h1234);
        start_and_clear(1'b0);
        stream_beats(2);
        check_done(1'b0);
        start_and_clear(1'b0);
        stream_beats(-1);
        check_done(1'b0);
        chk("lock_a0_kept", 128'(ah[0][0 +: DW]), 128'(16'h1234));

        // Back-to-back with start held high
        start_and_clear(1'b1);
        stream_beats(-1);
        check_done(1'b1);
        start = 1'b0;
        stream_beats(-1);
        check_done(1'b0);
        grid_check(1'b0);

        // Boundary: out-of-range A address, then write+start in the same cycle
        wr(1'b0, M * K, 16'hBEEF);
        v5 = DW'($urandom_range(1, 65535));
        ma[1][1] = v5;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd5; wr_data = v5; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        chk("ws_acc_clr", 128'(acc_clr), 128'(1));
        stream_beats(-1);
        check_done(1'b0);
        chk("ws_b2_a1", 128'(ah[2][1*DW +: DW]), 128'(v5));
        chk("oor_a00", 128'(ah[0][0 +: DW]), 128'(ma[0][0]));

        // Reset mid-stream at beat 3
        start_and_clear(1'b0);
        for (int t = 0; t < 4; t++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(valid), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_a", 128'(a_out), 128'(0));
        chk("mid_rst_b", 128'(b_out), 128'(0));
        @(negedge clk);
        chk("mid_rst_done", 128'(done), 128'(0));
        rst = 1'b0;
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ma[i][k] = '0;
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) mb[k][j] = '0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            chk("post_rst_no_done", 128'(done), 128'(0));
        end
        start_and_clear(1'b0);
        stream_beats(-1);
        check_done(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
